instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the control unit and supplies it with `instr`.
- Holds the architectural PC and issues word requests to instruction memory over a req/gnt/rvalid interface, one request outstanding at a time.
- Buffers returned words in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Applies redirects (jal/jalr/taken branch) signalled by `br_sel` and the ALU target, flushing wrong-path instructions.

---
 rtl/instr_fetch.sv | 192 +++++++++++++++++++
 tb/tb_instr_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, req/gnt/rvalid memory port, 2-entry FIFO, redirects.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_sel,
    input  logic [31:0] alu_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_four,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_addr, req_pc;
    logic        stale, stale_nxt;
    logic        push;
    logic        consume, redirect, mis_redirect, halted, halt_nxt;
    logic [31:0] target;
    logic [1:0]  count, count_pp;
    logic [31:0] head_instr, head_pc, tail_instr, tail_pc;
    logic        unused_bits;

    assign unused_bits = ^alu_data[1:0];
    assign instr_valid = (count != 2'd0);
    assign consume     = instr_valid && instr_ready;
    assign redirect    = consume && br_sel;
    assign halt_nxt    = redirect ? mis_redirect : halted;
    assign count_pp    = count + 2'd1 - {1'b0, consume};

    assign instr   = instr_valid ? head_instr : NOP_INSTR;
    assign pc      = instr_valid ? head_pc : fetch_pc;
    assign pc_four = pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic head_mis;

    assign target       = {alu_data[31:1], 1'b0};
    assign mis_redirect = redirect && alu_data[1];

    // The trap entry is only ever written into an empty FIFO, so only the head needs a flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted   <= 1'b0;
            head_mis <= 1'b0;
        end else if (redirect) begin
            halted   <= mis_redirect;
            head_mis <= mis_redirect;
        end else if (push || consume) begin
            head_mis <= 1'b0;
        end
    end

    assign fetch_misalign = instr_valid && head_mis;
`else
    assign target       = {alu_data[31:2], 2'b00};
    assign mis_redirect = 1'b0;
    assign halted       = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        stale_nxt    = stale;
        fetch_pc_nxt = redirect ? target : fetch_pc;
        push         = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = fetch_pc;
        case (state)
            IDLE: begin
                if (!halt_nxt && (redirect || count != 2'd2))
                    state_nxt = REQ;
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (imem_gnt) begin
                    if (redirect) begin
                        state_nxt = DROP;
                        stale_nxt = 1'b0;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else if (redirect) begin
                    stale_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    stale_nxt = 1'b0;
                    if (redirect) begin
                        state_nxt = IDLE;
                    end else if (stale) begin
                        state_nxt = halt_nxt ? IDLE : REQ;
                    end else begin
                        push         = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        state_nxt    = (count_pp != 2'd2) ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    stale_nxt = 1'b1;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                    stale_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // req_addr freezes the issued address so a redirect cannot disturb a request awaiting gnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            req_pc   <= RESET_PC;
            stale    <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            stale    <= stale_nxt;
            if (state_nxt == REQ && state != REQ)
                req_addr <= fetch_pc_nxt;
            if (state == REQ && imem_gnt)
                req_pc <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head_instr <= NOP_INSTR;
            head_pc    <= RESET_PC;
            tail_instr <= NOP_INSTR;
            tail_pc    <= RESET_PC;
        end else if (redirect) begin
            count      <= mis_redirect ? 2'd1 : 2'd0;
            head_instr <= NOP_INSTR;
            head_pc    <= target;
        end else begin
            case ({push, consume})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= imem_rdata;
                        head_pc    <= req_pc;
                    end else begin
                        tail_instr <= imem_rdata;
                        tail_pc    <= req_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_instr <= imem_rdata;
                        head_pc    <= req_pc;
                    end else begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= imem_rdata;
                        tail_pc    <= req_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a behavioural memory and stream model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_sel = 1'b0;
    logic [31:0] alu_data = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr, pc, pc_four;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk),
        .rst(rst),
        .br_sel(br_sel),
        .alu_data(alu_data),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .pc(pc),
        .pc_four(pc_four),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return ~a ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Memory: gnt after gnt_hold refused cycles, rvalid rv_lat cycles after gnt.
    int          gnt_hold = 0;
    int          rv_lat   = 1;
    int          hold_cnt = 0;
    int          rv_cnt   = 0;
    bit          rv_busy  = 1'b0;
    logic [31:0] rv_addr  = 32'd0;
    logic [31:0] grant_q[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_gnt    = 1'b0;
            if (rv_busy) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    rv_busy     = 1'b0;
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(rv_addr);
                end
            end
            if (imem_req) begin
                if (hold_cnt < gnt_hold) begin
                    hold_cnt++;
                end else begin
                    imem_gnt = 1'b1;
                    hold_cnt = 0;
                    rv_busy  = 1'b1;
                    rv_cnt   = rv_lat;
                    rv_addr  = imem_addr;
                    grant_q.push_back(imem_addr);
                end
            end
        end
    end

    // Stream model: decode must see consecutive PCs, restarting at the target after a redirect.
    logic [31:0] exp_pc = RESET_PC;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc    = RESET_PC;
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) begin
                    check("req_held", 32'(imem_req), 32'd1);
                    check("addr_held", imem_addr, prev_addr);
                end
                prev_wait = imem_req && !imem_gnt;
                prev_addr = imem_addr;
                if (instr_valid) begin
                    check("stream_pc", pc, exp_pc);
                    check("stream_instr", instr, word(exp_pc));
                    check("stream_pc_four", pc_four, exp_pc + 32'd4);
                    if (instr_ready)
                        exp_pc = br_sel ? (alu_data & 32'hFFFF_FFFC) : exp_pc + 32'd4;
                end else begin
                    check("empty_instr", instr, NOP);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit ready);
        rst         = 1'b1;
        br_sel      = 1'b0;
        alu_data    = 32'd0;
        instr_ready = ready;
        gnt_hold    = 0;
        rv_lat      = 1;
        hold_cnt    = 0;
        repeat (4) tick();
        grant_q.delete();
    endtask

    task automatic start(input bit ready);
        do_reset(ready);
        rst = 1'b0;
    endtask

    task automatic wait_grants(input int n, input string name);
        for (int i = 0; i < 60 && grant_q.size() < n; i++) tick();
        if (grant_q.size() < n) timeout_fail(name);
    endtask

    task automatic wait_valid(input string name);
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid) break;
        end
        if (i == 60) timeout_fail(name);
    endtask

    task automatic fill();
        start(1'b0);
        repeat (10) tick();
        @(negedge clk);
        check("bp_req_low", 32'(imem_req), 32'd0);
        check("bp_valid", 32'(instr_valid), 32'd1);
        check("bp_head_pc", pc, 32'h0000_0000);
        check("bp_head_instr", instr, 32'hA5FF_FFFF);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        check("bp_second_valid", 32'(instr_valid), 32'd1);
        check("bp_second_pc", pc, 32'h0000_0004);
    endtask

    initial begin
        int first;
        int nvalid;
        int i;

        // Reset state, first-fetch latency, in-order addresses, throughput.
        do_reset(1'b1);
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", pc, RESET_PC);
        check("rst_pc_four", pc_four, 32'h0000_0004);
        tick();
        rst   = 1'b0;
        first = 0;
        for (i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (instr_valid) begin
                first = i;
                break;
            end
        end
        check("first_valid_cycle", first, 32'd3);
        check("first_instr", instr, 32'hA5FF_FFFF);
        nvalid = 0;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid) nvalid++;
        end
        check("throughput", nvalid, 32'd5);
        if (grant_q.size() >= 3) begin
            check("addr0", grant_q[0], 32'h0000_0000);
            check("addr1", grant_q[1], 32'h0000_0004);
            check("addr2", grant_q[2], 32'h0000_0008);
        end else begin
            timeout_fail("addr_seq");
        end

        // Backpressure then redirect while the 0x8 fetch is in WAIT.
        fill();
        rv_lat = 3;
        for (i = 0; i < 20; i++) begin
            tick();
            if (imem_gnt) break;
        end
        if (i == 20) timeout_fail("wait_gnt8");
        tick();
        grant_q.delete();
        instr_ready = 1'b1;
        br_sel      = 1'b1;
        alu_data    = 32'h0000_0101;
        tick();
        instr_ready = 1'b0;
        br_sel      = 1'b0;
        @(negedge clk);
        check("wait_redir_flush", 32'(instr_valid), 32'd0);
        wait_grants(1, "wait_redir_gnt");
        if (grant_q.size() >= 1) check("wait_redir_addr", grant_q[0], 32'h0000_0100);
        wait_valid("wait_redir_valid");
        check("wait_redir_pc", pc, 32'h0000_0100);

        // Redirect while REQ is refused gnt for 3 cycles.
        fill();
        gnt_hold = 3;
        for (i = 0; i < 20; i++) begin
            tick();
            if (imem_req && !imem_gnt) break;
        end
        if (i == 20) timeout_fail("wait_req8");
        grant_q.delete();
        instr_ready = 1'b1;
        br_sel      = 1'b1;
        alu_data    = 32'h0000_0200;
        tick();
        instr_ready = 1'b0;
        br_sel      = 1'b0;
        @(negedge clk);
        check("req_redir_req", 32'(imem_req), 32'd1);
        check("req_redir_addr", imem_addr, 32'h0000_0008);
        wait_grants(1, "req_redir_gnt1");
        if (grant_q.size() >= 1) check("req_redir_gnt_addr", grant_q[0], 32'h0000_0008);
        gnt_hold = 0;
        wait_grants(2, "req_redir_gnt2");
        if (grant_q.size() >= 2) check("req_redir_target", grant_q[1], 32'h0000_0200);
        wait_valid("req_redir_valid");
        check("req_redir_pc", pc, 32'h0000_0200);

        // Redirect coinciding with rvalid, to the top word so fetch and pc_four wrap.
        fill();
        for (i = 0; i < 20; i++) begin
            tick();
            if (imem_rvalid) break;
        end
        if (i == 20) timeout_fail("wait_rvalid8");
        grant_q.delete();
        instr_ready = 1'b1;
        br_sel      = 1'b1;
        alu_data    = 32'hFFFF_FFFD;
        tick();
        br_sel = 1'b0;
        @(negedge clk);
        check("rv_redir_flush", 32'(instr_valid), 32'd0);
        wait_grants(1, "rv_redir_gnt");
        if (grant_q.size() >= 1) check("rv_redir_addr", grant_q[0], 32'hFFFF_FFFC);
        wait_valid("rv_redir_valid");
        check("rv_redir_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_four", pc_four, 32'h0000_0000);
        wait_grants(2, "wrap_gnt");
        if (grant_q.size() >= 2) check("wrap_fetch_addr", grant_q[1], 32'h0000_0000);
        repeat (6) tick();

        // Reset during WAIT, late rvalid must be ignored.
        start(1'b1);
        rv_lat = 2;
        for (i = 0; i < 20; i++) begin
            tick();
            if (imem_gnt) break;
        end
        if (i == 20) timeout_fail("wait_gnt0");
        tick();
        rst = 1'b1;
        grant_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("late_rv_valid0", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("late_rv_nopush", 32'(instr_valid), 32'd0);
        wait_grants(1, "late_rv_gnt");
        if (grant_q.size() >= 1) check("late_rv_addr", grant_q[0], RESET_PC);
        wait_valid("late_rv_valid");
        check("late_rv_pc", pc, RESET_PC);
        check("late_rv_instr", instr, 32'hA5FF_FFFF);

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
